// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// Request/response front-end for a small register memory (DEPTH x DATA_W).
// After reset it writes FILL_VAL to every location. It then accepts one
// read or write at a time over a valid/ready request channel, drives the
// memory port, and returns read data over a valid/ready response channel.
//
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   req_valid/req_ready    request handshake
//   req_we                 1 = write, 0 = read
//   req_addr, req_wdata    request address and write data
//   rsp_valid/rsp_ready    read response handshake
//   rsp_addr, rsp_rdata    address and data of the returned read
//   init_done              high once the fill sequence has finished
//   mem_addr, mem_wr_en,   memory port (all registered outputs)
//   mem_rd_en, mem_wdata
//   mem_rdata              memory read data, valid one cycle after mem_rd_en
module mem_req_ctrl #(
    parameter int                ADDR_W   = 2,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] FILL_VAL = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // init_cnt is one bit wider than the address so it can reach DEPTH,
    // which marks the edge that ends the fill sequence.
    localparam logic [ADDR_W:0] INIT_END = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR,
        RD,
        CAP,
        RSP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   init_cnt;
    logic [ADDR_W:0]   init_cnt_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_wr_en_nxt;
    logic              mem_rd_en_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              rsp_valid_nxt;
    logic [ADDR_W-1:0] rsp_addr_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              init_done_nxt;

    // Decoded from the state register alone so there is no combinational
    // path from the request inputs back to req_ready.
    assign req_ready = (state == IDLE);

    // State and every output register; everything clears on reset, which
    // drops any in-flight request or pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wr_en <= mem_wr_en_nxt;
            mem_rd_en <= mem_rd_en_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_addr  <= rsp_addr_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            init_done <= init_done_nxt;
        end
    end

    // Next-state and next-output logic. Every register holds its value by
    // default, so mem_addr/mem_wdata keep their last values while the
    // enables are low and the response stays stable while waiting in RSP.
    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        mem_addr_nxt  = mem_addr;
        mem_wr_en_nxt = mem_wr_en;
        mem_rd_en_nxt = mem_rd_en;
        mem_wdata_nxt = mem_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_addr_nxt  = rsp_addr;
        rsp_rdata_nxt = rsp_rdata;
        init_done_nxt = init_done;

        case (state)
            INIT: begin
                if (init_cnt == INIT_END) begin
                    mem_wr_en_nxt = 1'b0;
                    init_done_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    mem_wr_en_nxt = 1'b1;
                    mem_addr_nxt  = init_cnt[ADDR_W-1:0];
                    mem_wdata_nxt = FILL_VAL;
                    init_cnt_nxt  = init_cnt + 1'b1;
                end
            end

            IDLE: begin
                if (req_valid) begin
                    mem_addr_nxt = req_addr;
                    if (req_we) begin
                        mem_wr_en_nxt = 1'b1;
                        mem_wdata_nxt = req_wdata;
                        state_nxt     = WR;
                    end else begin
                        mem_rd_en_nxt = 1'b1;
                        state_nxt     = RD;
                    end
                end
            end

            // Writes are posted: one cycle of wr_en and straight back to idle.
            WR: begin
                mem_wr_en_nxt = 1'b0;
                state_nxt     = IDLE;
            end

            // The memory samples the read on this edge; its data shows up
            // on mem_rdata during CAP.
            RD: begin
                mem_rd_en_nxt = 1'b0;
                state_nxt     = CAP;
            end

            CAP: begin
                rsp_rdata_nxt = mem_rdata;
                rsp_addr_nxt  = mem_addr;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RSP;
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl
// Directed bench for mem_req_ctrl. A behavioural 4 x 8 register memory
// (registered read data) sits on the memory port. Expected values are
// hand-computed constants for each scenario.
module tb_mem_req_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic [1:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem_model [4];

    int test_count = 0;
    int fail_count = 0;

    mem_req_ctrl #(
        .ADDR_W   (2),
        .DATA_W   (8),
        .FILL_VAL (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register memory: write on wr_en, read data registered one cycle after rd_en.
    always @(posedge clk) begin
        if (mem_wr_en)
            mem_model[mem_addr] <= mem_wdata;
        if (mem_rd_en)
            mem_rdata <= mem_model[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] addr,
                                 input logic [7:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    // Called right after reset is released: four fill writes, then ready.
    task automatic checkInit();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("init_wr_en", 32'(mem_wr_en), 32'd1);
            checkOutput("init_addr", 32'(mem_addr), 32'(i));
            checkOutput("init_wdata", 32'(mem_wdata), 32'hFF);
            checkOutput("init_done_early", 32'(init_done), 32'd0);
            checkOutput("init_req_ready", 32'(req_ready), 32'd0);
        end
        tick();
        checkOutput("init_done", 32'(init_done), 32'd1);
        checkOutput("init_ready", 32'(req_ready), 32'd1);
        checkOutput("init_wr_off", 32'(mem_wr_en), 32'd0);
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_init_done", 32'(init_done), 32'd0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        reset = 1'b0;
    endtask

    task automatic doWrite(input logic [1:0] addr, input logic [7:0] data);
        waitReady();
        applyStimulus(1'b1, addr, data);
        tick();
        checkOutput("wr_en", 32'(mem_wr_en), 32'd1);
        checkOutput("wr_addr", 32'(mem_addr), 32'(addr));
        checkOutput("wr_wdata", 32'(mem_wdata), 32'(data));
        checkOutput("wr_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        tick();
        checkOutput("wr_en_off", 32'(mem_wr_en), 32'd0);
        checkOutput("wr_ready", 32'(req_ready), 32'd1);
        checkOutput("wr_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    task automatic doRead(input logic [1:0] addr, input logic [7:0] exp,
                          input int hold, input bit complete);
        waitReady();
        applyStimulus(1'b0, addr, 8'h00);
        tick();
        checkOutput("rd_en", 32'(mem_rd_en), 32'd1);
        checkOutput("rd_addr", 32'(mem_addr), 32'(addr));
        checkOutput("rd_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        tick();
        checkOutput("rd_en_off", 32'(mem_rd_en), 32'd0);
        checkOutput("rd_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp));
        checkOutput("rsp_addr", 32'(rsp_addr), 32'(addr));
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rdata", 32'(rsp_rdata), 32'(exp));
            checkOutput("hold_addr", 32'(rsp_addr), 32'(addr));
            checkOutput("hold_busy", 32'(req_ready), 32'd0);
        end
        if (complete) begin
            rsp_ready = 1'b1;
            tick();
            checkOutput("rsp_clear", 32'(rsp_valid), 32'd0);
            checkOutput("rsp_ready_again", 32'(req_ready), 32'd1);
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Fill sequence, then every location reads back the fill value.
        resetDut();
        checkInit();
        for (int a = 0; a < 4; a++)
            doRead(2'(a), 8'hFF, 0, 1'b1);

        // Write followed immediately by a read of the same address.
        doWrite(2'd2, 8'hA5);
        doRead(2'd2, 8'hA5, 0, 1'b1);

        // Back-pressured response held for five cycles.
        doRead(2'd1, 8'hFF, 5, 1'b1);

        // Write requested during init waits until the fill finishes.
        reset = 1'b1;
        tick();
        applyStimulus(1'b1, 2'd0, 8'h3C);
        reset = 1'b0;
        checkInit();
        tick();
        checkOutput("late_wr_en", 32'(mem_wr_en), 32'd1);
        checkOutput("late_wr_addr", 32'(mem_addr), 32'd0);
        checkOutput("late_wr_wdata", 32'(mem_wdata), 32'h3C);
        req_valid = 1'b0;
        tick();
        checkOutput("late_wr_ready", 32'(req_ready), 32'd1);
        doRead(2'd0, 8'h3C, 0, 1'b1);
        doRead(2'd1, 8'hFF, 0, 1'b1);

        // Reset while a response is pending: it drops at once, fill reruns.
        doWrite(2'd3, 8'h5A);
        doRead(2'd3, 8'h5A, 2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("arst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("arst_init_done", 32'(init_done), 32'd0);
        tick();
        reset = 1'b0;
        checkInit();
        for (int a = 0; a < 4; a++)
            doRead(2'(a), 8'hFF, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
